// File: rtl/wfifo_wr_arbiter.sv
// Round-robin arbiter that shares one async-FIFO write port between NREQ packet sources.
// A grant is held for a whole packet. An optional tag word carrying the requester id precedes each packet.
module wfifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TAG_EN     = 1
) (
    input  logic                       i_wclk,
    input  logic                       i_wrst_n,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NREQ-1:0]            i_req_last,
    output logic [NREQ-1:0]            o_req_ready,
    input  logic                       i_wfull,
    output logic                       o_winc,
    output logic [DATA_WIDTH-1:0]      o_wdata,
    output logic [ID_WIDTH-1:0]        o_grant_id,
    output logic                       o_busy
);

    typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

    state_t                state_reg, state_next;
    logic [ID_WIDTH-1:0]   grant_reg, grant_next;
    logic [ID_WIDTH-1:0]   last_grant_reg, last_grant_next;

    logic [DATA_WIDTH-1:0] req_word [NREQ];
    logic [DATA_WIDTH-1:0] grant_word;
    logic [DATA_WIDTH-1:0] tag_word;
    logic                  grant_valid;
    logic                  grant_last;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_id;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign req_word[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest valid requester after last_grant wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            for (int k = 0; k < NREQ; k++) begin
                if (((int'(last_grant_reg) + 1 + i) % NREQ) == k && i_req_valid[k]) begin
                    pick_found = 1'b1;
                    pick_id    = ID_WIDTH'(k);
                end
            end
        end
    end

    always_comb begin
        grant_word  = '0;
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_reg == ID_WIDTH'(k)) begin
                grant_word  = req_word[k];
                grant_valid = i_req_valid[k];
                grant_last  = i_req_last[k];
            end
        end
        tag_word                 = '0;
        tag_word[ID_WIDTH-1:0]   = grant_reg;
    end

    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= ID_WIDTH'(NREQ - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        o_winc          = 1'b0;
        o_wdata         = '0;
        o_req_ready     = '0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_id;
                    state_next = (TAG_EN != 0) ? TAG : DATA;
                end
            end
            TAG: begin
                o_wdata = tag_word;
                o_winc  = !i_wfull;
                if (!i_wfull) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                for (int k = 0; k < NREQ; k++) begin
                    o_req_ready[k] = (grant_reg == ID_WIDTH'(k)) && !i_wfull;
                end
                o_wdata = grant_word;
                o_winc  = grant_valid && !i_wfull;
                // The grant is only released once the last word is actually accepted.
                if (grant_valid && !i_wfull && grant_last) begin
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_grant_id = grant_reg;
    assign o_busy     = (state_reg != IDLE);

endmodule
